// File: rtl/vend_controller.sv
// vend_controller: coin-credit vending controller.
// Accumulates coin credit up to MAX_CREDIT and accepts product selections.
// It drives the dispense mechanism and returns change in a single-cycle strobe.
// Optional feature: define VEND_TIMEOUT_EN to enable the dispense watchdog.
// The watchdog refunds a failed vend after DISPENSE_TIMEOUT cycles and
// pulses fault. Without the macro, DISPENSE waits for dispense_done forever.
module vend_controller #(
  parameter int unsigned MAX_CREDIT       = 99,
  parameter int unsigned DISPENSE_TIMEOUT = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       coin_pulse,
  input  logic [7:0] coin_value,
  input  logic       sel_valid,
  input  logic [7:0] sel_price,
  input  logic       cancel,
  input  logic       dispense_done,
  output logic [7:0] credit,
  output logic [1:0] state,
  output logic       dispense,
  output logic       change_valid,
  output logic [7:0] change_value,
  output logic       coin_reject,
  output logic       insufficient,
  output logic       fault
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CREDIT   = 2'd1,
    DISPENSE = 2'd2,
    CHANGE   = 2'd3
  } state_e;

  // Out-of-range parameters stop elaboration.
  if (MAX_CREDIT < 1 || MAX_CREDIT > 255) begin : g_bad_max_credit
    $error("vend_controller: MAX_CREDIT must be 1..255");
  end
  if (DISPENSE_TIMEOUT < 1 || DISPENSE_TIMEOUT > 24'hFF_FFFF) begin : g_bad_timeout
    $error("vend_controller: DISPENSE_TIMEOUT must be 1..2^24-1");
  end

  localparam logic [8:0] MAX_SUM = 9'(MAX_CREDIT);

  state_e     state_q, state_d;
  logic [7:0] credit_q, credit_d;
  logic       dispense_q, dispense_d;
  logic       change_valid_q, change_valid_d;
  logic [7:0] change_value_q, change_value_d;
  logic       coin_reject_q, coin_reject_d;
  logic       insufficient_q, insufficient_d;
  logic       fault_q, fault_d;

  // Nine-bit sums so that a large coin can never wrap past the ceiling.
  logic [8:0] coin_sum;
  logic [7:0] vend_credit;
  logic [8:0] vend_sum;

`ifdef VEND_TIMEOUT_EN
  localparam logic [23:0] TIMEOUT_LAST = 24'(DISPENSE_TIMEOUT - 1);
  logic [23:0] cnt_q, cnt_d;
  logic [7:0]  price_q, price_d;
`endif

  // State register and registered outputs.
  // NOTE: sequential state uses non-blocking (<=) so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      credit_q       <= '0;
      dispense_q     <= 1'b0;
      change_valid_q <= 1'b0;
      change_value_q <= '0;
      coin_reject_q  <= 1'b0;
      insufficient_q <= 1'b0;
      fault_q        <= 1'b0;
`ifdef VEND_TIMEOUT_EN
      cnt_q          <= '0;
      price_q        <= '0;
`endif
    end else begin
      state_q        <= state_d;
      credit_q       <= credit_d;
      dispense_q     <= dispense_d;
      change_valid_q <= change_valid_d;
      change_value_q <= change_value_d;
      coin_reject_q  <= coin_reject_d;
      insufficient_q <= insufficient_d;
      fault_q        <= fault_d;
`ifdef VEND_TIMEOUT_EN
      cnt_q          <= cnt_d;
      price_q        <= price_d;
`endif
    end
  end

  // Next-state, next-credit and next-output decode.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_d        = state_q;
    credit_d       = credit_q;
    change_valid_d = 1'b0;
    change_value_d = '0;
    coin_reject_d  = 1'b0;
    insufficient_d = 1'b0;
    fault_d        = 1'b0;
`ifdef VEND_TIMEOUT_EN
    cnt_d          = '0;  // zero outside DISPENSE, so it is clear on entry
    price_d        = price_q;
`endif

    coin_sum    = {1'b0, credit_q} + {1'b0, coin_value};
    vend_credit = credit_q - sel_price;
    vend_sum    = {1'b0, vend_credit} + {1'b0, coin_value};

    unique case (state_q)
      IDLE, CREDIT: begin
        if (cancel && state_q == CREDIT) begin
          // Refund everything; a coin in the same cycle is bounced and the selection dropped.
          state_d        = CHANGE;
          credit_d       = '0;
          change_valid_d = 1'b1;
          change_value_d = credit_q;
          coin_reject_d  = coin_pulse;
        end else if (sel_valid && sel_price <= credit_q) begin
          // Price is judged against pre-coin credit; the coin adds to the remainder.
          state_d  = DISPENSE;
          credit_d = vend_credit;
          if (coin_pulse) begin
            if (vend_sum <= MAX_SUM) credit_d      = vend_sum[7:0];
            else                     coin_reject_d = 1'b1;
          end
`ifdef VEND_TIMEOUT_EN
          price_d = sel_price;
`endif
        end else begin
          insufficient_d = sel_valid;
          if (coin_pulse) begin
            if (coin_sum <= MAX_SUM) credit_d      = coin_sum[7:0];
            else                     coin_reject_d = 1'b1;
          end
          state_d = (credit_d == '0) ? IDLE : CREDIT;
        end
      end

      DISPENSE: begin
        coin_reject_d = coin_pulse;
        if (dispense_done) begin
          if (credit_q != '0) begin
            state_d        = CHANGE;
            credit_d       = '0;
            change_valid_d = 1'b1;
            change_value_d = credit_q;
          end else begin
            state_d = IDLE;
          end
        end
`ifdef VEND_TIMEOUT_EN
        else if (cnt_q == TIMEOUT_LAST) begin
          // Failed vend: price goes back on the credit and is returned at once as change.
          state_d        = CHANGE;
          fault_d        = 1'b1;
          credit_d       = '0;
          change_valid_d = 1'b1;
          change_value_d = credit_q + price_q;
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
`endif
      end

      CHANGE: begin
        coin_reject_d = coin_pulse;
        credit_d      = '0;
        state_d       = IDLE;
      end

      default: state_d = IDLE;
    endcase

    dispense_d = (state_d == DISPENSE);
  end

  assign credit       = credit_q;
  assign state        = state_q;
  assign dispense     = dispense_q;
  assign change_valid = change_valid_q;
  assign change_value = change_value_q;
  assign coin_reject  = coin_reject_q;
  assign insufficient = insufficient_q;
  assign fault        = fault_q;

endmodule

// File: tb/tb_vend_controller.sv
// tb_vend_controller: directed self-checking bench for vend_controller.
// Inputs change 1 ns after each rising edge; outputs are sampled there too.
module tb_vend_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       coin_pulse;
  logic [7:0] coin_value;
  logic       sel_valid;
  logic [7:0] sel_price;
  logic       cancel;
  logic       dispense_done;
  logic [7:0] credit;
  logic [1:0] state;
  logic       dispense;
  logic       change_valid;
  logic [7:0] change_value;
  logic       coin_reject;
  logic       insufficient;
  logic       fault;

  int checks = 0;
  int errors = 0;

  vend_controller #(
    .MAX_CREDIT      (99),
    .DISPENSE_TIMEOUT(16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .coin_pulse   (coin_pulse),
    .coin_value   (coin_value),
    .sel_valid    (sel_valid),
    .sel_price    (sel_price),
    .cancel       (cancel),
    .dispense_done(dispense_done),
    .credit       (credit),
    .state        (state),
    .dispense     (dispense),
    .change_valid (change_valid),
    .change_value (change_value),
    .coin_reject  (coin_reject),
    .insufficient (insufficient),
    .fault        (fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock edge with the given inputs held, then strobes drop back to 0.
  task automatic step(input logic cp, input logic [7:0] cv, input logic sv,
                      input logic [7:0] sp, input logic cn, input logic dd);
    coin_pulse    = cp;
    coin_value    = cv;
    sel_valid     = sv;
    sel_price     = sp;
    cancel        = cn;
    dispense_done = dd;
    @(posedge clk);
    #1;
    coin_pulse    = 1'b0;
    coin_value    = '0;
    sel_valid     = 1'b0;
    sel_price     = '0;
    cancel        = 1'b0;
    dispense_done = 1'b0;
  endtask

  task automatic coin(input logic [7:0] v);
    step(1'b1, v, 1'b0, 8'd0, 1'b0, 1'b0);
  endtask

  task automatic sel(input logic [7:0] p);
    step(1'b0, 8'd0, 1'b1, p, 1'b0, 1'b0);
  endtask

  task automatic idle_cycle();
    step(1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0);
  endtask

  task automatic done();
    step(1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".credit"},       credit,       0);
    check({tag, ".state"},        state,        0);
    check({tag, ".dispense"},     dispense,     0);
    check({tag, ".change_valid"}, change_valid, 0);
    check({tag, ".change_value"}, change_value, 0);
    check({tag, ".coin_reject"},  coin_reject,  0);
    check({tag, ".insufficient"}, insufficient, 0);
    check({tag, ".fault"},        fault,        0);
  endtask

  initial begin
    rst_n         = 1'b0;
    coin_pulse    = 1'b0;
    coin_value    = '0;
    sel_valid     = 1'b0;
    sel_price     = '0;
    cancel        = 1'b0;
    dispense_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");

    // First event right after reset release is taken on the next edge.
    rst_n = 1'b1;
    coin(8'd5);
    check("first_coin.credit", credit, 5);
    check("first_coin.state",  state,  1);

    // Basic vend with change: 5+2, buy 4, change 3.
    coin(8'd2);
    check("vend.credit7", credit, 7);
    sel(8'd4);
    check("vend.state",    state,    2);
    check("vend.dispense", dispense, 1);
    check("vend.credit3",  credit,   3);
    idle_cycle();
    check("vend.hold_dispense", dispense, 1);
    done();
    check("vend.change_valid", change_valid, 1);
    check("vend.change_value", change_value, 3);
    check("vend.change_state", state,        3);
    check("vend.change_credit", credit,      0);
    check("vend.change_dispense", dispense,  0);
    idle_cycle();
    check("vend.idle_state",   state,        0);
    check("vend.change_drop",  change_valid, 0);
    check("vend.value_drop",   change_value, 0);

    // Credit ceiling: 97 + 5 bounced, 97 + 2 reaches 99 exactly.
    coin(8'd50);
    coin(8'd47);
    check("ceil.credit97", credit, 97);
    coin(8'd5);
    check("ceil.reject", coin_reject, 1);
    check("ceil.credit_kept", credit, 97);
    idle_cycle();
    check("ceil.reject_pulse", coin_reject, 0);
    coin(8'd2);
    check("ceil.credit99", credit, 99);
    check("ceil.no_reject", coin_reject, 0);
    step(1'b0, 8'd0, 1'b0, 8'd0, 1'b1, 1'b0);
    check("ceil.cancel_value", change_value, 99);
    idle_cycle();
    check("ceil.idle", state, 0);

    // Insufficient credit: 3 against price 4.
    coin(8'd3);
    sel(8'd4);
    check("insuf.pulse",  insufficient, 1);
    check("insuf.state",  state,        1);
    check("insuf.credit", credit,       3);
    idle_cycle();
    check("insuf.pulse_drop", insufficient, 0);

    // Same-cycle coin 2 and selection 6 at credit 6.
    coin(8'd3);
    check("combo.credit6", credit, 6);
    step(1'b1, 8'd2, 1'b1, 8'd6, 1'b0, 1'b0);
    check("combo.state",  state,  2);
    check("combo.credit", credit, 2);
    step(1'b1, 8'd1, 1'b1, 8'd1, 1'b1, 1'b0);
    check("combo.disp_coin_reject", coin_reject,  1);
    check("combo.disp_sel_ignored", insufficient, 0);
    check("combo.disp_credit",      credit,       2);
    check("combo.disp_state",       state,        2);
    done();
    check("combo.change_value", change_value, 2);
    idle_cycle();

    // Cancel plus coin in CREDIT: coin bounced, full refund.
    coin(8'd8);
    step(1'b1, 8'd1, 1'b0, 8'd0, 1'b1, 1'b0);
    check("cancel.reject",       coin_reject,  1);
    check("cancel.change_valid", change_valid, 1);
    check("cancel.change_value", change_value, 8);
    check("cancel.credit",       credit,       0);
    check("cancel.state",        state,        3);
    idle_cycle();
    check("cancel.idle", state, 0);

    // Cancel in IDLE does nothing; selection at zero credit is refused.
    step(1'b0, 8'd0, 1'b0, 8'd0, 1'b1, 1'b0);
    check("idle_cancel.state",  state,        0);
    check("idle_cancel.change", change_valid, 0);
    sel(8'd1);
    check("idle_sel.insufficient", insufficient, 1);
    check("idle_sel.state",        state,        0);
    coin(8'd100);
    check("idle_big.reject", coin_reject, 1);
    check("idle_big.state",  state,       0);
    check("idle_big.credit", credit,      0);

    // Exact-price vend leaving zero credit; then a stalled mechanism.
    coin(8'd5);
    sel(8'd5);
    check("exact.state",  state,  2);
    check("exact.credit", credit, 0);
`ifdef VEND_TIMEOUT_EN
    begin
      int waited = 0;
      while (fault !== 1'b1 && waited < 40) begin
        idle_cycle();
        waited++;
      end
      check("timeout.cycles",       waited,       16);
      check("timeout.fault",        fault,        1);
      check("timeout.change_valid", change_valid, 1);
      check("timeout.change_value", change_value, 5);
      check("timeout.state",        state,        3);
      check("timeout.credit",       credit,       0);
      idle_cycle();
      check("timeout.fault_pulse",  fault,        0);
      check("timeout.idle",         state,        0);
    end
    // dispense_done on the timeout cycle wins.
    coin(8'd5);
    sel(8'd5);
    repeat (15) idle_cycle();
    check("race.still_dispensing", state, 2);
    done();
    check("race.no_fault", fault, 0);
    check("race.idle",     state, 0);
    check("race.no_change", change_valid, 0);
`else
    repeat (40) idle_cycle();
    check("notimeout.state", state, 2);
    check("notimeout.fault", fault, 0);
    done();
    check("notimeout.idle",      state,        0);
    check("notimeout.no_change", change_valid, 0);
`endif

    // Asynchronous reset in the middle of a vend with credit outstanding.
    coin(8'd9);
    sel(8'd4);
    check("midrst.state",  state,  2);
    check("midrst.credit", credit, 5);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle_cycle();
    check("midrst.no_change", change_valid, 0);
    check("midrst.idle",      state,        0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
